// File: rtl/tcp_buf_pkg.sv
// Shared constants and write-FSM state type for the 512-bit packet data buffer.
// Both the write side (write_module) and the read side (read_module) import this.
package tcp_buf_pkg;

    localparam int unsigned DATA_BITS = 512;
    localparam int unsigned ADDR_BITS = 10;
    localparam int unsigned MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_RUN   = 2'd1,
        WR_FLUSH = 2'd2,
        WR_DONE  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/buf_ptr_cmp.sv
// Combinational compare of two address_bits+1 wide circular buffer pointers.
// The extra MSB tells a completely full buffer apart from an empty one.
module buf_ptr_cmp
    import tcp_buf_pkg::*;
#(
    parameter int unsigned address_bits = ADDR_BITS,
    parameter int unsigned mem_depth    = MEM_DEPTH
) (
    input  logic [address_bits:0] wr_ptr_i,
    input  logic [address_bits:0] rd_ptr_i,
    output logic [address_bits:0] occupancy_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [address_bits:0] DEPTH_W = (address_bits + 1)'(mem_depth);

    // Pointer difference wraps modulo 2*mem_depth by natural overflow
    always_comb begin
        occupancy_o = wr_ptr_i - rd_ptr_i;
        full_o      = (occupancy_o == DEPTH_W);
        empty_o     = (occupancy_o == '0);
    end

endmodule

// File: rtl/write_module.sv
// Write side of the shared packet buffer: pops an FWFT RX FIFO and writes
// each word to BRAM port A one cycle later at a circular write pointer.
// The pointer advances at pop time; wr_done marks that the last write landed.
module write_module
    import tcp_buf_pkg::*;
#(
    parameter int unsigned data_bits    = DATA_BITS,
    parameter int unsigned address_bits = ADDR_BITS,
    parameter int unsigned mem_depth    = MEM_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_wr_en,
    input  logic [address_bits:0]   wr_len,
    input  logic [data_bits-1:0]    fifo_rx_data,
    input  logic                    fifo_rx_empty,
    output logic                    fifo_rx_rd_en,
    input  logic [address_bits:0]   rd_ptr_in,
    output logic [address_bits-1:0] address_a,
    output logic [data_bits-1:0]    datain_a,
    output logic                    ena,
    output logic                    wea,
    output logic [address_bits:0]   wr_ptr,
    output logic                    busy,
    output logic                    wr_done,
    output logic                    wr_err
);

    localparam logic [address_bits:0] DEPTH_W = (address_bits + 1)'(mem_depth);
    localparam logic [address_bits:0] PTR_ONE = (address_bits + 1)'(1);

    wr_state_e               state_q, state_d;
    logic [address_bits:0]   rem_q, rem_d;
    logic [address_bits:0]   ptr_q, ptr_d;
    logic                    err_q, err_d;
    logic                    ena_q;
    logic [address_bits-1:0] addr_q;
    logic [data_bits-1:0]    data_q;

    logic                    full;
    logic                    pop;
    logic [address_bits:0]   occupancy_unused;
    logic                    empty_unused;

    buf_ptr_cmp #(
        .address_bits (address_bits),
        .mem_depth    (mem_depth)
    ) u_ptr_cmp (
        .wr_ptr_i    (ptr_q),
        .rd_ptr_i    (rd_ptr_in),
        .occupancy_o (occupancy_unused),
        .full_o      (full),
        .empty_o     (empty_unused)
    );

    // Pop qualifier, FSM next state, pointer and remaining-length update
    always_comb begin
        pop     = (state_q == WR_RUN) && !fifo_rx_empty && !full && (rem_q != '0);
        state_d = state_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        err_d   = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (start_wr_en) begin
                    if (wr_len == '0) begin
                        state_d = WR_DONE;
                    end else if (wr_len > DEPTH_W) begin
                        err_d = 1'b1;
                    end else begin
                        rem_d   = wr_len;
                        state_d = WR_RUN;
                    end
                end
            end
            WR_RUN: begin
                if (pop) begin
                    ptr_d = ptr_q + PTR_ONE;
                    rem_d = rem_q - PTR_ONE;
                    if (rem_q == PTR_ONE) begin
                        state_d = WR_FLUSH;
                    end
                end
            end
            WR_FLUSH: state_d = WR_DONE;
            WR_DONE:  state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WR_IDLE;
            rem_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // One-cycle write pipeline: the word popped this cycle is written next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ena_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ena_q <= pop;
            if (pop) begin
                addr_q <= ptr_q[address_bits-1:0];
                data_q <= fifo_rx_data;
            end
        end
    end

    assign fifo_rx_rd_en = pop;
    assign ena           = ena_q;
    assign wea           = ena_q;
    assign address_a     = addr_q;
    assign datain_a      = data_q;
    assign wr_ptr        = ptr_q;
    assign busy          = (state_q == WR_RUN) || (state_q == WR_FLUSH);
    assign wr_done       = (state_q == WR_DONE);
    assign wr_err        = err_q;

endmodule

// File: tb/tb_write_module.sv
// Directed testbench for write_module with an FWFT FIFO model and a BRAM beat monitor.
module tb_write_module;

    localparam int DB = 512;
    localparam int AB = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_wr_en = 1'b0;
    logic [AB:0]   wr_len = '0;
    logic [DB-1:0] fifo_rx_data;
    logic          fifo_rx_empty;
    logic          fifo_rx_rd_en;
    logic [AB:0]   rd_ptr_in = '0;
    logic [AB-1:0] address_a;
    logic [DB-1:0] datain_a;
    logic          ena, wea;
    logic [AB:0]   wr_ptr;
    logic          busy, wr_done, wr_err;

    int tests = 0;
    int fails = 0;

    write_module #(
        .data_bits    (DB),
        .address_bits (AB),
        .mem_depth    (1024)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_wr_en   (start_wr_en),
        .wr_len        (wr_len),
        .fifo_rx_data  (fifo_rx_data),
        .fifo_rx_empty (fifo_rx_empty),
        .fifo_rx_rd_en (fifo_rx_rd_en),
        .rd_ptr_in     (rd_ptr_in),
        .address_a     (address_a),
        .datain_a      (datain_a),
        .ena           (ena),
        .wea           (wea),
        .wr_ptr        (wr_ptr),
        .busy          (busy),
        .wr_done       (wr_done),
        .wr_err        (wr_err)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [DB-1:0] fmem [0:2047];
    int head = 0;
    int tail = 0;
    assign fifo_rx_empty = (head >= tail);
    assign fifo_rx_data  = fmem[head[10:0]];
    always @(posedge clk) if (fifo_rx_rd_en && head < tail) head <= head + 1;

    // Beat / pulse monitor, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [AB-1:0] b_addr [$];
    logic [31:0]   b_data [$];
    int            b_cyc  [$];
    int done_cnt, err_cnt, done_cyc, wea_bad;
    bit busy_seen;
    always @(negedge clk) begin
        if (ena) begin
            b_addr.push_back(address_a);
            b_data.push_back(datain_a[31:0]);
            b_cyc.push_back(cyc);
        end
        if (wr_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wr_err) err_cnt++;
        if (busy) busy_seen = 1'b1;
        if (ena !== wea) wea_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        b_addr.delete();
        b_data.delete();
        b_cyc.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        wea_bad   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic push(input logic [31:0] v);
        fmem[tail[10:0]] = {{(DB-32){1'b0}}, v};
        tail++;
    endtask

    task automatic pulse_start(input int len);
        start_wr_en = 1'b1;
        wr_len      = len[AB:0];
        tick();
        start_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt != d0), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int bad;
        int n;
        clr();
        #2 reset = 1'b1;
        tick();
        tick();
        // Reset state
        check("rst_ena",     64'(ena), 64'd0);
        check("rst_wea",     64'(wea), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_wr_ptr",  64'(wr_ptr), 64'd0);
        check("rst_done",    64'(wr_done), 64'd0);
        check("rst_err",     64'(wr_err), 64'd0);
        check("rst_addr",    64'(address_a), 64'd0);
        check("rst_rd_en",   64'(fifo_rx_rd_en), 64'd0);
        reset = 1'b0;
        tick();

        // Basic 4-word frame
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        clr();
        pulse_start(4);
        wait_done(40, "t1_done_timeout");
        tick();
        check("t1_beats", 64'(b_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < b_addr.size()) begin
                check("t1_addr", 64'(b_addr[i]), 64'(i));
                check("t1_data", 64'(b_data[i]), 64'h0A0 + 64'(i));
            end
        end
        if (b_cyc.size() == 4) begin
            check("t1_back_to_back", 64'(b_cyc[3] - b_cyc[0]), 64'd3);
            check("t1_done_after_last", 64'(done_cyc - b_cyc[3]), 64'd1);
        end
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_wr_ptr",   64'(wr_ptr), 64'd4);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_wea_eq_ena", 64'(wea_bad), 64'd0);

        // FIFO starvation mid-frame
        do_reset();
        clr();
        push(32'hB0);
        pulse_start(3);
        repeat (8) tick();
        check("t2_gap_beats", 64'(b_addr.size()), 64'd1);
        check("t2_gap_busy",  64'(busy), 64'd1);
        check("t2_gap_rd_en", 64'(fifo_rx_rd_en), 64'd0);
        check("t2_gap_done",  64'(done_cnt), 64'd0);
        push(32'hB1);
        push(32'hB2);
        wait_done(40, "t2_done_timeout");
        tick();
        check("t2_beats", 64'(b_addr.size()), 64'd3);
        if (b_addr.size() == 3) begin
            check("t2_addr0", 64'(b_addr[0]), 64'd0);
            check("t2_addr1", 64'(b_addr[1]), 64'd1);
            check("t2_addr2", 64'(b_addr[2]), 64'd2);
            check("t2_data0", 64'(b_data[0]), 64'hB0);
            check("t2_data2", 64'(b_data[2]), 64'hB2);
        end
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        // Fill the whole buffer, then stall on full, then wrap
        do_reset();
        rd_ptr_in = '0;
        clr();
        for (int i = 0; i < 1024; i++) push(32'h1000 + 32'(i));
        pulse_start(1024);
        wait_done(1200, "t3_fill_timeout");
        tick();
        check("t3_fill_beats", 64'(b_addr.size()), 64'd1024);
        bad = 0;
        for (int i = 0; i < b_addr.size(); i++) begin
            if (b_addr[i] !== 10'(i) || b_data[i] !== 32'h1000 + 32'(i)) bad++;
        end
        check("t3_fill_content", 64'(bad), 64'd0);
        check("t3_fill_wr_ptr",  64'(wr_ptr), 64'd1024);
        clr();
        push(32'hD0);
        push(32'hD1);
        pulse_start(2);
        repeat (10) tick();
        check("t3_full_beats", 64'(b_addr.size()), 64'd0);
        check("t3_full_busy",  64'(busy), 64'd1);
        check("t3_full_rd_en", 64'(fifo_rx_rd_en), 64'd0);
        rd_ptr_in = 11'd2;
        wait_done(40, "t3_wrap_timeout");
        tick();
        check("t3_wrap_beats", 64'(b_addr.size()), 64'd2);
        if (b_addr.size() == 2) begin
            check("t3_wrap_addr0", 64'(b_addr[0]), 64'd0);
            check("t3_wrap_addr1", 64'(b_addr[1]), 64'd1);
            check("t3_wrap_data0", 64'(b_data[0]), 64'hD0);
            check("t3_wrap_data1", 64'(b_data[1]), 64'hD1);
        end
        check("t3_wrap_wr_ptr", 64'(wr_ptr), 64'd1026);

        // Illegal length and zero length
        clr();
        pulse_start(1025);
        repeat (4) tick();
        check("t4_err_cnt",   64'(err_cnt), 64'd1);
        check("t4_err_beats", 64'(b_addr.size()), 64'd0);
        check("t4_err_busy",  64'(busy_seen), 64'd0);
        check("t4_err_done",  64'(done_cnt), 64'd0);
        clr();
        pulse_start(0);
        repeat (4) tick();
        check("t4_zero_done",  64'(done_cnt), 64'd1);
        check("t4_zero_beats", 64'(b_addr.size()), 64'd0);
        check("t4_zero_err",   64'(err_cnt), 64'd0);
        check("t4_zero_busy",  64'(busy_seen), 64'd0);

        // Ignored start while busy, then async reset abort after 3 writes
        do_reset();
        rd_ptr_in = '0;
        clr();
        for (int i = 0; i < 8; i++) push(32'hF0 + 32'(i));
        pulse_start(8);
        start_wr_en = 1'b1;
        wr_len      = 11'd1025;
        tick();
        start_wr_en = 1'b0;
        n = 0;
        while (b_addr.size() < 3 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t5_three_beats", 64'(b_addr.size()), 64'd3);
        reset = 1'b1;
        #1;
        check("t5_rst_ena",    64'(ena), 64'd0);
        check("t5_rst_wea",    64'(wea), 64'd0);
        check("t5_rst_wr_ptr", 64'(wr_ptr), 64'd0);
        check("t5_rst_busy",   64'(busy), 64'd0);
        check("t5_rst_addr",   64'(address_a), 64'd0);
        check("t5_rst_data",   64'(datain_a[31:0]), 64'd0);
        check("t5_rst_rd_en",  64'(fifo_rx_rd_en), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("t5_no_done", 64'(done_cnt), 64'd0);
        check("t5_no_err",  64'(err_cnt), 64'd0);
        clr();
        pulse_start(2);
        wait_done(40, "t5_new_timeout");
        tick();
        check("t5_new_beats", 64'(b_addr.size()), 64'd2);
        if (b_addr.size() == 2) begin
            check("t5_new_addr0", 64'(b_addr[0]), 64'd0);
            check("t5_new_addr1", 64'(b_addr[1]), 64'd1);
            check("t5_new_data0", 64'(b_data[0]), 64'hF3);
            check("t5_new_data1", 64'(b_data[1]), 64'hF4);
        end
        check("t5_new_wr_ptr", 64'(wr_ptr), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
